// File: rtl/grid_mover_if.sv
// grid_mover_if: request/ack, position and map-BRAM signals of the grid mover
interface grid_mover_if #(
  parameter int NUM_ENT = 2,
  parameter int X_W = 4,
  parameter int Y_W = 4,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
);
  logic [NUM_ENT-1:0] move_req;
  logic [2*NUM_ENT-1:0] move_dir;
  logic [NUM_ENT-1:0] move_ack;
  logic [NUM_ENT-1:0] move_ok;
  logic [X_W*NUM_ENT-1:0] pos_x;
  logic [Y_W*NUM_ENT-1:0] pos_y;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic busy;
  modport master (
    output move_req, move_dir, bram_data,
    input move_ack, move_ok, pos_x, pos_y, bram_addr, busy
  );
  modport slave (
    input move_req, move_dir, bram_data,
    output move_ack, move_ok, pos_x, pos_y, bram_addr, busy
  );
endinterface

// File: rtl/grid_mover.sv
// grid_mover: round-robin move arbiter with bounds and map walkability check; define GRID_MOVER_COLLIDE_EN to also block moves onto occupied tiles
module grid_mover #(
  parameter int NUM_ENT = 2,
  parameter int X_W = 4,
  parameter int Y_W = 4,
  parameter int MAP_W = 16,
  parameter int MAP_H = 16,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int MAP_BASE = 0,
  parameter int BLOCK_BIT = 15,
  parameter int START_X = 1,
  parameter int START_Y = 1
) (
  input logic clk,
  input logic rstn,
  grid_mover_if.slave bus
);
  localparam int IW = NUM_ENT > 1 ? $clog2(NUM_ENT) : 1;
  localparam logic [X_W:0] MW = (X_W+1)'(MAP_W);
  localparam logic [Y_W:0] MH = (Y_W+1)'(MAP_H);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(MAP_BASE);
  localparam logic [ADDR_W-1:0] ROW = ADDR_W'(MAP_W);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, ACK} state_t;
  state_t state;
  logic [IW-1:0] rr, win, gnt, c;
  logic [IW:0] s;
  logic found, in_bounds, blocked;
  logic [X_W-1:0] px [NUM_ENT];
  logic [Y_W-1:0] py [NUM_ENT];
  logic [1:0] dir_a [NUM_ENT];
  logic [X_W*NUM_ENT-1:0] pxf;
  logic [Y_W*NUM_ENT-1:0] pyf;
  logic [X_W-1:0] tx;
  logic [Y_W-1:0] ty;
  logic [X_W:0] nx;
  logic [Y_W:0] ny;
  logic [1:0] dir;
  logic [NUM_ENT-1:0] ack, ok;
  logic [ADDR_W-1:0] addr, taddr;
  // unpack request directions and pack positions for the renderer
  always_comb begin
    pxf = '0;
    pyf = '0;
    for (int k = 0; k < NUM_ENT; k++) begin
      pxf[k*X_W +: X_W] = px[k];
      pyf[k*Y_W +: Y_W] = py[k];
      dir_a[k] = bus.move_dir[2*k +: 2];
    end
  end
  // first requester at or after the round-robin pointer, wrapping
  always_comb begin
    found = 1'b0;
    gnt = rr;
    s = '0;
    c = '0;
    for (int k = 0; k < NUM_ENT; k++) begin
      s = {1'b0, rr} + (IW+1)'(k);
      s = s >= (IW+1)'(NUM_ENT) ? s - (IW+1)'(NUM_ENT) : s;
      c = s[IW-1:0];
      if (!found && bus.move_req[c]) begin
        found = 1'b1;
        gnt = c;
      end
    end
  end
  // target tile of the candidate, widened by one bit so underflow reads as out of bounds
  always_comb begin
    dir = dir_a[gnt];
    nx = {1'b0, px[gnt]};
    ny = {1'b0, py[gnt]};
    nx = dir == 2'b10 ? nx - (X_W+1)'(1) : dir == 2'b11 ? nx + (X_W+1)'(1) : nx;
    ny = dir == 2'b00 ? ny - (Y_W+1)'(1) : dir == 2'b01 ? ny + (Y_W+1)'(1) : ny;
    in_bounds = nx < MW && ny < MH;
    taddr = BASE + ADDR_W'(ny[Y_W-1:0]) * ROW + ADDR_W'(nx[X_W-1:0]);
  end
`ifdef GRID_MOVER_COLLIDE_EN
  logic hit;
  // another entity already standing on the target tile
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_ENT; k++)
      if (IW'(k) != win && px[k] == tx && py[k] == ty) hit = 1'b1;
    blocked = bus.bram_data[BLOCK_BIT] | hit;
  end
`else
  assign blocked = bus.bram_data[BLOCK_BIT];
`endif
  // arbitration FSM: grant, BRAM read, commit, one-cycle ack
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      rr <= '0;
      win <= '0;
      tx <= '0;
      ty <= '0;
      addr <= '0;
      ack <= '0;
      ok <= '0;
      for (int k = 0; k < NUM_ENT; k++) begin
        px[k] <= X_W'(START_X + k);
        py[k] <= Y_W'(START_Y);
      end
    end else begin
      ack <= '0;
      ok <= '0;
      case (state)
        IDLE: if (found) begin
          win <= gnt;
          tx <= nx[X_W-1:0];
          ty <= ny[Y_W-1:0];
          if (in_bounds) begin
            addr <= taddr;
            state <= ADDR;
          end else begin
            ack[gnt] <= 1'b1;
            state <= ACK;
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          ack[win] <= 1'b1;
          ok[win] <= !blocked;
          if (!blocked) begin
            px[win] <= tx;
            py[win] <= ty;
          end
          state <= ACK;
        end
        default: begin
          rr <= win == IW'(NUM_ENT - 1) ? '0 : win + IW'(1);
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.pos_x = pxf;
  assign bus.pos_y = pyf;
  assign bus.bram_addr = addr;
  assign bus.move_ack = ack;
  assign bus.move_ok = ok;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: directed checks of grid_mover with a behavioural 1-cycle map BRAM
module tb_grid_mover;
`ifdef GRID_MOVER_COLLIDE_EN
  localparam bit COL = 1'b1;
`else
  localparam bit COL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;
  grid_mover_if bus();
  grid_mover dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  // map BRAM: one-cycle synchronous read
  always @(posedge clk) bus.bram_data <= mem[bus.bram_addr[7:0]];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask
  // one request; req is dropped and dir scrambled right after the grant
  task automatic do_move(input int ent, input logic [1:0] dir, output logic ok, output int lat, output logic [18:0] addr1);
    lat = 0;
    ok = 1'b0;
    addr1 = '0;
    bus.move_dir[2*ent +: 2] = dir;
    bus.move_req[ent] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin
        addr1 = bus.bram_addr;
        bus.move_req[ent] = 1'b0;
        bus.move_dir[2*ent +: 2] = ~dir;
      end
      if (bus.move_ack != 0) begin
        lat = n;
        ok = bus.move_ok[ent];
        check("ack_vec", 32'(bus.move_ack), 32'(1) << ent);
        break;
      end
    end
    if (lat == 0) check("ack_timeout", 0, 1);
    @(negedge clk);
    check("ack_pulse", 32'(bus.move_ack), 0);
  endtask
  initial begin
    logic ok;
    int lat;
    logic [18:0] a1;
    logic [1:0] order [$];
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    bus.move_req = '0;
    bus.move_dir = '0;
    do_reset();
    @(negedge clk);
    check("rst_pos_x", 32'(bus.pos_x), 32'h21);
    check("rst_pos_y", 32'(bus.pos_y), 32'h11);
    check("rst_ack", 32'(bus.move_ack), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_addr", 32'(bus.bram_addr), 0);
    do_move(0, 2'b11, ok, lat, a1);
    check("right_lat", lat, 3);
    check("right_addr", 32'(a1), 18);
    check("right_ok", 32'(ok), 32'(!COL));
    check("right_pos_x", 32'(bus.pos_x), COL ? 32'h21 : 32'h22);
    check("right_pos_y", 32'(bus.pos_y), 32'h11);
    do_reset();
    do_move(0, 2'b10, ok, lat, a1);
    check("left_lat", lat, 3);
    check("left_addr", 32'(a1), 16);
    check("left_ok", 32'(ok), 1);
    check("left_pos_x", 32'(bus.pos_x), 32'h20);
    do_move(0, 2'b10, ok, lat, a1);
    check("oob_lat", lat, 1);
    check("oob_ok", 32'(ok), 0);
    check("oob_no_read", 32'(bus.bram_addr), 16);
    check("oob_pos_x", 32'(bus.pos_x), 32'h20);
    mem[0] = 16'h8000;
    do_move(0, 2'b00, ok, lat, a1);
    check("blk_lat", lat, 3);
    check("blk_addr", 32'(a1), 0);
    check("blk_ok", 32'(ok), 0);
    check("blk_pos_x", 32'(bus.pos_x), 32'h20);
    check("blk_pos_y", 32'(bus.pos_y), 32'h11);
    do_reset();
    bus.move_dir = 4'b0101;
    bus.move_req = 2'b11;
    for (int n = 0; n < 40 && order.size() < 4; n++) begin
      @(negedge clk);
      if (bus.move_ack != 0) begin
        order.push_back(bus.move_ack);
        check("rr_ok", 32'(bus.move_ok), 32'(bus.move_ack));
      end
    end
    bus.move_req = 2'b00;
    check("rr_count", order.size(), 4);
    for (int i = 0; i < order.size(); i++) check("rr_order", 32'(order[i]), i % 2 == 0 ? 1 : 2);
    repeat (3) @(negedge clk);
    check("rr_pos_x", 32'(bus.pos_x), 32'h21);
    check("rr_pos_y", 32'(bus.pos_y), 32'h33);
    bus.move_dir[1:0] = 2'b11;
    bus.move_req[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_busy", 32'(bus.busy), 1);
    rstn = 1'b0;
    #1;
    check("abort_pos_x", 32'(bus.pos_x), 32'h21);
    check("abort_pos_y", 32'(bus.pos_y), 32'h11);
    check("abort_ack", 32'(bus.move_ack), 0);
    check("abort_busy_low", 32'(bus.busy), 0);
    bus.move_req = '0;
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.move_ack != 0 || bus.busy) seen++;
    end
    check("abort_idle", seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
